// File: rtl/fwrisc_trace_buffer.sv
// fwrisc_trace_buffer: assembles one trace record per retired instruction
// (pc, instr, rd write-back, memory access) and buffers them in a FIFO.
// Ports: clock/reset (sync, active-high); tracer inputs pc, instr, ivalid,
// rd_waddr/rd_wdata/rd_write, maddr/mdata/mstrb/mwrite/mvalid;
// record stream t_valid/t_ready plus t_* fields; status count, overflow,
// drop_count. Never stalls the core: full FIFO drops and counts records.
module fwrisc_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     ivalid,
    input  logic [5:0]               rd_waddr,
    input  logic [31:0]              rd_wdata,
    input  logic                     rd_write,
    input  logic [31:0]              maddr,
    input  logic [31:0]              mdata,
    input  logic [3:0]               mstrb,
    input  logic                     mwrite,
    input  logic                     mvalid,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [31:0]              t_pc,
    output logic [31:0]              t_instr,
    output logic                     t_rd_wr,
    output logic [5:0]               t_rd_addr,
    output logic [31:0]              t_rd_data,
    output logic                     t_mem,
    output logic [31:0]              t_maddr,
    output logic [31:0]              t_mdata,
    output logic [3:0]               t_mstrb,
    output logic                     t_mwrite,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_wr;
        logic [5:0]  rd_addr;
        logic [31:0] rd_data;
        logic        mem;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [3:0]  mstrb;
        logic        mwrite;
    } rec_t;

    typedef enum logic {IDLE, PEND} pend_e;

    pend_e       rd_st, rd_st_n;
    pend_e       m_st, m_st_n;
    logic [5:0]  p_rd_addr;
    logic [31:0] p_rd_data;
    logic [31:0] p_maddr;
    logic [31:0] p_mdata;
    logic [3:0]  p_mstrb;
    logic        p_mwrite;

    rec_t          fifo [DEPTH];
    rec_t          rec;
    rec_t          head;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Pending trackers: any commit retires the pending access, since a
    // same-cycle strobe belongs to the committing record.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_st <= IDLE;
            m_st  <= IDLE;
        end else begin
            rd_st <= rd_st_n;
            m_st  <= m_st_n;
        end
    end

    always_comb begin
        rd_st_n = rd_st;
        m_st_n  = m_st;
        if (ivalid) begin
            rd_st_n = IDLE;
            m_st_n  = IDLE;
        end else begin
            if (rd_write) rd_st_n = PEND;
            if (mvalid)   m_st_n  = PEND;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || ivalid) begin
            p_rd_addr <= '0;
            p_rd_data <= '0;
            p_maddr   <= '0;
            p_mdata   <= '0;
            p_mstrb   <= '0;
            p_mwrite  <= 1'b0;
        end else begin
            if (rd_write) begin
                p_rd_addr <= rd_waddr;
                p_rd_data <= rd_wdata;
            end
            if (mvalid) begin
                p_maddr  <= maddr;
                p_mdata  <= mdata;
                p_mstrb  <= mstrb;
                p_mwrite <= mwrite;
            end
        end
    end

    always_comb begin
        rec       = '0;
        rec.pc    = pc;
        rec.instr = instr;
        if (rd_write) begin
            rec.rd_wr   = 1'b1;
            rec.rd_addr = rd_waddr;
            rec.rd_data = rd_wdata;
        end else if (rd_st == PEND) begin
            rec.rd_wr   = 1'b1;
            rec.rd_addr = p_rd_addr;
            rec.rd_data = p_rd_data;
        end
        if (mvalid) begin
            rec.mem    = 1'b1;
            rec.maddr  = maddr;
            rec.mdata  = mdata;
            rec.mstrb  = mstrb;
            rec.mwrite = mwrite;
        end else if (m_st == PEND) begin
            rec.mem    = 1'b1;
            rec.maddr  = p_maddr;
            rec.mdata  = p_mdata;
            rec.mstrb  = p_mstrb;
            rec.mwrite = p_mwrite;
        end
    end

    assign full = (count_q == (AW+1)'(DEPTH));
    assign pop  = t_valid && t_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can
    // still accept a record when the consumer is draining.
    assign push = ivalid && (!full || pop);
    assign drop = ivalid && !push;

    always_ff @(posedge clock) begin
        if (push) fifo[wptr] <= rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign t_valid = (count_q != '0);
    assign count   = count_q;
    assign head    = t_valid ? fifo[rptr] : '0;

    assign t_pc      = head.pc;
    assign t_instr   = head.instr;
    assign t_rd_wr   = head.rd_wr;
    assign t_rd_addr = head.rd_addr;
    assign t_rd_data = head.rd_data;
    assign t_mem     = head.mem;
    assign t_maddr   = head.maddr;
    assign t_mdata   = head.mdata;
    assign t_mstrb   = head.mstrb;
    assign t_mwrite  = head.mwrite;

endmodule

// File: tb/tb_fwrisc_trace_buffer.sv
// tb_fwrisc_trace_buffer: directed stimulus with a queue scoreboard and a
// monitor that checks every record popped from the trace stream.
module tb_fwrisc_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc, instr;
    logic        ivalid;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_write;
    logic [31:0] maddr, mdata;
    logic [3:0]  mstrb;
    logic        mwrite, mvalid;
    logic        t_valid, t_ready;
    logic [31:0] t_pc, t_instr;
    logic        t_rd_wr;
    logic [5:0]  t_rd_addr;
    logic [31:0] t_rd_data;
    logic        t_mem;
    logic [31:0] t_maddr, t_mdata;
    logic [3:0]  t_mstrb;
    logic        t_mwrite;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_wr;
        logic [5:0]  rd_addr;
        logic [31:0] rd_data;
        logic        mem;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [3:0]  mstrb;
        logic        mwrite;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fwrisc_trace_buffer #(.DEPTH(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .pc(pc), .instr(instr), .ivalid(ivalid),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .maddr(maddr), .mdata(mdata), .mstrb(mstrb),
        .mwrite(mwrite), .mvalid(mvalid),
        .t_valid(t_valid), .t_ready(t_ready),
        .t_pc(t_pc), .t_instr(t_instr),
        .t_rd_wr(t_rd_wr), .t_rd_addr(t_rd_addr), .t_rd_data(t_rd_data),
        .t_mem(t_mem), .t_maddr(t_maddr), .t_mdata(t_mdata),
        .t_mstrb(t_mstrb), .t_mwrite(t_mwrite),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    function automatic rec_t mk(input logic [31:0] p, input logic [31:0] i,
                                input logic rw, input logic [5:0] ra,
                                input logic [31:0] rdat, input logic m,
                                input logic [31:0] ma, input logic [31:0] md,
                                input logic [3:0] ms, input logic mw);
        rec_t r;
        r = '{p, i, rw, ra, rdat, m, ma, md, ms, mw};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        ivalid = 0; rd_write = 0; mvalid = 0;
    endtask

    task automatic retire(input logic [31:0] p, input logic [31:0] i);
        pc = p; instr = i; ivalid = 1;
    endtask

    task automatic set_rd(input logic [5:0] a, input logic [31:0] d);
        rd_write = 1; rd_waddr = a; rd_wdata = d;
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w);
        mvalid = 1; maddr = a; mdata = d; mstrb = s; mwrite = w;
    endtask

    always @(negedge clock) begin
        if (!reset && t_valid && t_ready) begin
            rec_t act, exp;
            act = '{t_pc, t_instr, t_rd_wr, t_rd_addr, t_rd_data, t_mem,
                    t_maddr, t_mdata, t_mstrb, t_mwrite};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL record: unexpected pc=0x%0h", t_pc);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL record: got %h expected %h", act, exp);
                end
            end
        end
    end

    initial begin
        reset = 1; t_ready = 0; pc = 0; instr = 0;
        rd_waddr = 0; rd_wdata = 0; maddr = 0; mdata = 0;
        mstrb = 0; mwrite = 0;
        idle_in();
        cyc(); cyc();
        check("rst_valid", 32'(t_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_pc", t_pc, 0);
        reset = 0;
        cyc();

        // addi x5, x0, 7 with write-back in the retire cycle
        t_ready = 1;
        retire(32'h100, 32'h00700293); set_rd(5, 32'h7);
        sb.push_back(mk(32'h100, 32'h00700293, 1, 5, 7, 0, 0, 0, 0, 0));
        cyc(); idle_in();
        check("t1_valid", 32'(t_valid), 1);
        check("t1_pc", t_pc, 32'h100);
        cyc();
        check("t1_count", 32'(count), 0);
        check("empty_rd", t_rd_data, 0);

        // load: mem access two cycles before retire
        set_mem(32'h2000, 32'hDEADBEEF, 4'hF, 0);
        cyc(); idle_in(); cyc();
        retire(32'h104, 32'h00002503); set_rd(10, 32'hDEADBEEF);
        sb.push_back(mk(32'h104, 32'h00002503, 1, 10, 32'hDEADBEEF,
                        1, 32'h2000, 32'hDEADBEEF, 4'hF, 0));
        cyc(); idle_in();
        retire(32'h108, 32'h00000013);
        sb.push_back(mk(32'h108, 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); idle_in();

        // last mem access wins; same-cycle rd beats pending rd
        set_mem(32'h10, 32'h11, 4'h1, 1); set_rd(3, 32'h33);
        cyc(); idle_in();
        set_mem(32'h20, 32'h22, 4'h3, 1);
        cyc(); idle_in();
        retire(32'h10C, 32'h00a12023); set_rd(4, 32'h44);
        sb.push_back(mk(32'h10C, 32'h00a12023, 1, 4, 32'h44,
                        1, 32'h20, 32'h22, 4'h3, 1));
        cyc(); idle_in();
        // rd in the cycle after commit belongs to the next instruction
        set_rd(0, 32'h99);
        cyc(); idle_in();
        retire(32'h110, 32'h09900013);
        sb.push_back(mk(32'h110, 32'h09900013, 1, 0, 32'h99,
                        0, 0, 0, 0, 0));
        cyc(); idle_in();
        cyc();
        check("t3_count", 32'(count), 0);

        // overflow: 10 retirements, no consumer
        t_ready = 0;
        for (int i = 0; i < 10; i++) begin
            retire(32'h1000 + 32'(4 * i), 32'h13);
            if (i < 8)
                sb.push_back(mk(32'h1000 + 32'(4 * i), 32'h13,
                                0, 0, 0, 0, 0, 0, 0, 0));
            cyc();
        end
        idle_in();
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drop", 32'(drop_count), 2);
        cyc();
        check("stall_pc", t_pc, 32'h1000);

        // full FIFO with simultaneous pop accepts the push
        t_ready = 1; retire(32'h2000, 32'h13);
        sb.push_back(mk(32'h2000, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); idle_in(); t_ready = 0;
        check("fp_count", 32'(count), 8);
        check("fp_drop", 32'(drop_count), 2);
        t_ready = 1;
        for (int i = 0; i < 40 && count != 0; i++) cyc();
        check("drain_count", 32'(count), 0);
        check("drain_sb", 32'(sb.size()), 0);

        // reset mid-operation
        t_ready = 0;
        for (int i = 0; i < 5; i++) begin
            retire(32'h3000 + 32'(4 * i), 32'h13);
            cyc();
        end
        idle_in();
        set_mem(32'h4000, 32'h55, 4'hF, 1);
        cyc(); idle_in();
        check("pre_count", 32'(count), 5);
        check("pre_ovf", 32'(overflow), 1);
        reset = 1;
        cyc();
        check("mrst_count", 32'(count), 0);
        check("mrst_valid", 32'(t_valid), 0);
        check("mrst_ovf", 32'(overflow), 0);
        check("mrst_drop", 32'(drop_count), 0);
        reset = 0;
        t_ready = 1;
        retire(32'h200, 32'h13);
        sb.push_back(mk(32'h200, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(); idle_in();
        check("post_mem", 32'(t_mem), 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        check("final_sb", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fwrisc_trace_buffer.md
Name: fwrisc_trace_buffer

Overview:
Sits directly downstream of the core's tracer interface, alongside the formal arithmetic checker, consuming the same retirement signals. Assembles one record per retired instruction: pc, instr, rd write-back and any memory access. Buffers records in a small FIFO and presents them on a valid/ready stream for the bench scoreboard or host dump logic. Flags overflow instead of stalling the core, because the tracer interface has no back-pressure.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the saturating dropped-record counter.

Ports:
clock  input  1  clock
reset  input  1  reset; synchronous, active-high
pc  input  32  pc of the instruction in execute
instr  input  32  instruction word in execute
ivalid  input  1  instruction retires this cycle
rd_waddr  input  6  write-back address
rd_wdata  input  32  write-back data
rd_write  input  1  write-back strobe
maddr  input  32  memory address
mdata  input  32  memory data
mstrb  input  4  byte strobes
mwrite  input  1  1 = store, 0 = load
mvalid  input  1  memory access completes this cycle
t_valid  output  1  record available at head
t_ready  input  1  consumer accepts head record
t_pc  output  32  record pc
t_instr  output  32  record instruction
t_rd_wr  output  1  record performed a write-back
t_rd_addr  output  6  write-back address (0 when t_rd_wr=0)
t_rd_data  output  32  write-back data (0 when t_rd_wr=0)
t_mem  output  1  record performed a memory access
t_maddr  output  32  access address (0 when t_mem=0)
t_mdata  output  32  access data (0 when t_mem=0)
t_mstrb  output  4  access strobes (0 when t_mem=0)
t_mwrite  output  1  access was a store
count  output  $clog2(DEPTH)+1  entries held
overflow  output  1  sticky: at least one record dropped
drop_count  output  CNT_W  records dropped, saturating

Behaviour:
- Reset clears all of the following: FIFO pointers, count=0, t_valid=0, pending registers, overflow=0, drop_count=0. All t_* fields read 0 while empty. Reset asserted mid-operation discards buffered and pending data in the same cycle.
- Pending mem register: loaded on mvalid. A later mvalid before commit overwrites it (last access wins).
- Pending rd register: loaded on rd_write. A later rd_write before commit overwrites it.
- Commit happens on ivalid. The record takes pc and instr from the current cycle.
  - An rd_write or mvalid in the ivalid cycle belongs to the committing record and takes precedence over pending values.
  - Pending registers clear on commit.
  - An rd_write or mvalid in the cycle after commit belongs to the next instruction.
- Writes to rd_waddr=0 are recorded unmodified; the buffer does not filter. Consumers check $zero.
- Push is accepted when count<DEPTH, or when count==DEPTH and a pop (t_valid&&t_ready) occurs in the same cycle.
- Otherwise the record is dropped:
  - overflow is set and stays set until reset;
  - drop_count increments and saturates at 2^CNT_W-1;
  - FIFO contents are untouched.
- Latency: a record committed at cycle N is visible with t_valid=1 at cycle N+1 (first-word fall-through head register).
- Stream rules:
  - t_* fields are stable while t_valid && !t_ready.
  - Pop occurs on t_valid && t_ready.
  - Push and pop in the same cycle leave count unchanged.
  - t_ready while empty has no effect.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- No state machine beyond FIFO occupancy. The pending-capture logic is a two-state (idle / pending) tracker for each of the mem and rd registers.

Test Plan:
- Retire addi at pc=0x100 with rd_write rd=5 data=0x7 in the ivalid cycle, t_ready=1 -> next cycle t_valid=1, t_pc=0x100, t_rd_wr=1, t_rd_addr=5, t_rd_data=0x7, t_mem=0; then count returns to 0.
- Load: mvalid at cycle 3 (maddr=0x2000, mdata=0xDEADBEEF, mstrb=0xF, mwrite=0), ivalid at cycle 5 with rd_write -> one record with t_mem=1 and those values; the following record has t_mem=0.
- Two mvalid before one ivalid (maddr 0x10, then 0x20) -> record t_maddr=0x20.
- t_ready=0, 10 retirements with DEPTH=8 -> count=8, overflow=1, drop_count=2; draining yields the first 8 pcs in order.
- Full FIFO, ivalid and t_ready in the same cycle -> push accepted, count stays 8, drop_count unchanged.
- Reset asserted with count=5 and a pending mem access -> next cycle count=0, t_valid=0, overflow=0; the first post-reset record has t_mem=0.
